// File: rtl/tmds_pkg.sv
// Shared constants for the DVI TMDS encoder: control tokens, reset token,
// default disparity-counter width and a ones-count helper.
package tmds_pkg;

   localparam int CNT_W_DEF = 5;

   localparam logic [9:0] CTRL_00     = 10'b1101010100;
   localparam logic [9:0] CTRL_01     = 10'b0010101011;
   localparam logic [9:0] CTRL_10     = 10'b0101010100;
   localparam logic [9:0] CTRL_11     = 10'b1010101011;
   localparam logic [9:0] RESET_TOKEN = CTRL_00;

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One DVI 8b/10b TMDS channel: stage 1 transition minimisation, stage 2 DC balance.
// TMDS_DISP_MON_EN adds a disp output carrying the registered running disparity.
module tmds_channel_enc
   import tmds_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        data,
   input  logic [1:0]        ctrl,
   input  logic              de,
   output logic [9:0]        sym
`ifdef TMDS_DISP_MON_EN
   ,
   output logic signed [CNT_W-1:0] disp
`endif
);

   localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
   localparam logic signed [CNT_W-1:0] ZERO = '0;

   // Streaming datapath: one symbol per clock, no handshake or backpressure.
   logic [3:0] n1_d;
   logic       use_xnor;
   logic [8:0] qm_d;
   logic [8:0] qm_q;
   logic       de_q;
   logic [1:0] ctrl_q;

   always_comb begin
      n1_d     = ones8(data);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
      qm_d     = '0;
      qm_d[0]  = data[0];
      for (int i = 1; i < 8; i++) begin
         qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
      end
      qm_d[8] = ~use_xnor;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm_q   <= '0;
         de_q   <= 1'b0;
         ctrl_q <= 2'b00;
      end else begin
         qm_q   <= qm_d;
         de_q   <= de;
         ctrl_q <= ctrl;
      end
   end

   logic signed [CNT_W-1:0] cnt_q;
   logic signed [CNT_W-1:0] cnt_d;
   logic signed [CNT_W-1:0] n1_s;
   logic signed [CNT_W-1:0] n0_s;
   logic [3:0]              n1_q;
   logic                    cnt_pos;
   logic                    cnt_neg;
   logic [9:0]              sym_d;

   assign n1_q    = ones8(qm_q[7:0]);
   assign n1_s    = CNT_W'(n1_q);
   assign n0_s    = CNT_W'(4'd8 - n1_q);
   assign cnt_neg = cnt_q[CNT_W-1];
   assign cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != ZERO);

   always_comb begin
      sym_d = RESET_TOKEN;
      cnt_d = ZERO;
      if (!de_q) begin
         // Blanking: control token, disparity restarts from zero.
         case (ctrl_q)
            2'b00: sym_d = CTRL_00;
            2'b01: sym_d = CTRL_01;
            2'b10: sym_d = CTRL_10;
            2'b11: sym_d = CTRL_11;
            default: sym_d = CTRL_00;
         endcase
      end else if ((cnt_q == ZERO) || (n1_q == 4'd4)) begin
         sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_d = qm_q[8] ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
      end else if ((cnt_pos && (n1_q > 4'd4)) || (cnt_neg && (n1_q < 4'd4))) begin
         sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_d = cnt_q + (qm_q[8] ? TWO : ZERO) + n0_s - n1_s;
      end else begin
         sym_d = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_d = cnt_q + n1_s - n0_s - (qm_q[8] ? ZERO : TWO);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym   <= RESET_TOKEN;
         cnt_q <= ZERO;
      end else begin
         sym   <= sym_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef TMDS_DISP_MON_EN
   assign disp = cnt_q;
`endif

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Top of the DVI TMDS encoder: sync inversion and control mapping into three channels.
// TMDS_DISP_MON_EN adds DISP_R/G/B running-disparity monitor outputs.
module dvi_tmds_encoder
   import tmds_pkg::*;
#(
   parameter bit HSYNC_INV = 1'b0,
   parameter bit VSYNC_INV = 1'b0,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  RED,
   input  logic [7:0]  GREEN,
   input  logic [7:0]  BLUE,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic        READY,
   output logic [9:0]  TMDS_R,
   output logic [9:0]  TMDS_G,
   output logic [9:0]  TMDS_B
`ifdef TMDS_DISP_MON_EN
   ,
   output logic signed [CNT_W-1:0] DISP_R,
   output logic signed [CNT_W-1:0] DISP_G,
   output logic signed [CNT_W-1:0] DISP_B
`endif
);

   logic hs;
   logic vs;

   assign hs = HSYNC ^ HSYNC_INV;
   assign vs = VSYNC ^ VSYNC_INV;

   // Only blue carries sync; red and green always send the C=00 token in blanking.
   tmds_channel_enc #(.CNT_W(CNT_W)) u_enc_b (
      .clk   (CLK),
      .rst_n (RST_N),
      .data  (BLUE),
      .ctrl  ({vs, hs}),
      .de    (READY),
      .sym   (TMDS_B)
`ifdef TMDS_DISP_MON_EN
      ,
      .disp  (DISP_B)
`endif
   );

   tmds_channel_enc #(.CNT_W(CNT_W)) u_enc_g (
      .clk   (CLK),
      .rst_n (RST_N),
      .data  (GREEN),
      .ctrl  (2'b00),
      .de    (READY),
      .sym   (TMDS_G)
`ifdef TMDS_DISP_MON_EN
      ,
      .disp  (DISP_G)
`endif
   );

   tmds_channel_enc #(.CNT_W(CNT_W)) u_enc_r (
      .clk   (CLK),
      .rst_n (RST_N),
      .data  (RED),
      .ctrl  (2'b00),
      .de    (READY),
      .sym   (TMDS_R)
`ifdef TMDS_DISP_MON_EN
      ,
      .disp  (DISP_R)
`endif
   );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: directed vector table, reset corners,
// and a randomised run against an independent encoding model.
module tb_dvi_tmds_encoder;

   localparam logic [9:0] K00 = 10'b1101010100;
   localparam logic [9:0] K01 = 10'b0010101011;
   localparam logic [9:0] K10 = 10'b0101010100;
   localparam logic [9:0] K11 = 10'b1010101011;
   localparam logic [9:0] Z0  = 10'b0100000000;
   localparam logic [9:0] Z1  = 10'b1111111111;
   localparam logic [9:0] F1  = 10'b1000000000;

   // clock / reset
   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] RED, GREEN, BLUE;
   logic       HSYNC, VSYNC, READY;
   logic [9:0] TMDS_R, TMDS_G, TMDS_B;

   always #5 CLK = ~CLK;

   dvi_tmds_encoder dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .RED    (RED),
      .GREEN  (GREEN),
      .BLUE   (BLUE),
      .HSYNC  (HSYNC),
      .VSYNC  (VSYNC),
      .READY  (READY),
      .TMDS_R (TMDS_R),
      .TMDS_G (TMDS_G),
      .TMDS_B (TMDS_B)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check3(input string name, input logic [9:0] er, input logic [9:0] eg,
                         input logic [9:0] eb);
      check({name, "_r"}, TMDS_R, er);
      check({name, "_g"}, TMDS_G, eg);
      check({name, "_b"}, TMDS_B, eb);
   endtask

   // driver
   task automatic drive(input logic rdy, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      READY = rdy;
      HSYNC = hs;
      VSYNC = vs;
      RED   = r;
      GREEN = g;
      BLUE  = b;
   endtask

   // directed vector table: expected symbols appear two cycles after the inputs
   typedef struct {
      logic       rdy, hs, vs;
      logic [7:0] r, g, b;
      logic [9:0] er, eg, eb;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic rdy, input logic hs, input logic vs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
      vec_t v;
      v.rdy = rdy; v.hs = hs; v.vs = vs;
      v.r = r; v.g = g; v.b = b;
      v.er = er; v.eg = eg; v.eb = eb;
      return v;
   endfunction

   // independent reference model
   int mcnt[3];

   function automatic logic [9:0] model_enc(input int ch, input logic de, input logic [1:0] c,
                                            input logic [7:0] d);
      int         n1, ones;
      logic       x;
      logic [7:0] q;
      logic       q8;
      logic [9:0] s;
      if (!de) begin
         mcnt[ch] = 0;
         case (c)
            2'b00: s = K00;
            2'b01: s = K01;
            2'b10: s = K10;
            default: s = K11;
         endcase
         return s;
      end
      n1 = $countones(d);
      x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q8   = !x;
      ones = $countones(q);
      if (mcnt[ch] == 0 || ones == 4) begin
         s = q8 ? {2'b01, q} : {2'b10, ~q};
         mcnt[ch] += q8 ? (2 * ones - 8) : (8 - 2 * ones);
      end else if ((mcnt[ch] > 0 && ones > 4) || (mcnt[ch] < 0 && ones < 4)) begin
         s = {1'b1, q8, ~q};
         mcnt[ch] += (q8 ? 2 : 0) + 8 - 2 * ones;
      end else begin
         s = {1'b0, q8, q};
         mcnt[ch] += 2 * ones - 8 - (q8 ? 0 : 2);
      end
      return s;
   endfunction

   // scoreboard
   logic [29:0] exp_q[$];

   initial begin
      logic [29:0] e;
      logic        rdy, hs, vs;
      logic [7:0]  r, g, b;

      vecs[0]  = mk(0,0,0, 8'h00,8'h00,8'h00, K00,K00,K00);
      vecs[1]  = mk(0,1,0, 8'h00,8'h00,8'h00, K00,K00,K01);
      vecs[2]  = mk(0,0,1, 8'h00,8'h00,8'h00, K00,K00,K10);
      vecs[3]  = mk(0,1,1, 8'h00,8'h00,8'h00, K00,K00,K11);
      vecs[4]  = mk(0,0,0, 8'h00,8'h00,8'h00, K00,K00,K00);
      vecs[5]  = mk(1,0,0, 8'h00,8'h00,8'h00, Z0,Z0,Z0);
      vecs[6]  = mk(1,0,0, 8'h00,8'h00,8'h00, Z1,Z1,Z1);
      vecs[7]  = mk(0,0,0, 8'h00,8'h00,8'h00, K00,K00,K00);
      vecs[8]  = mk(1,0,0, 8'h00,8'h00,8'hFF, Z0,Z0,F1);
      vecs[9]  = mk(0,0,0, 8'h00,8'h00,8'h00, K00,K00,K00);
      vecs[10] = mk(1,0,0, 8'h00,8'h00,8'h00, Z0,Z0,Z0);
      vecs[11] = mk(0,0,0, 8'h00,8'h00,8'h00, K00,K00,K00);
      vecs[12] = mk(1,0,0, 8'h55,8'h01,8'hF0, 10'b0100110011,10'b0111111111,10'b1000000101);
      vecs[13] = mk(1,0,0, 8'h55,8'h01,8'hF0, 10'b0100110011,10'b1100000000,10'b0011111010);
      vecs[14] = mk(1,0,0, 8'h00,8'h01,8'hF0, Z0,10'b1100000000,10'b0011111010);
      vecs[15] = mk(1,0,0, 8'h55,8'h01,8'hF0, 10'b0100110011,10'b0111111111,10'b1000000101);
      vecs[16] = mk(1,1,1, 8'h00,8'h00,8'h00, Z1,Z0,Z1);
      vecs[17] = mk(0,1,1, 8'h00,8'h00,8'h00, K00,K00,K11);

      // reset held, then released in blanking
      RST_N = 1'b0;
      drive(0,0,0, 8'h00,8'h00,8'h00);
      repeat (5) begin
         @(negedge CLK);
         check3("in_reset", K00, K00, K00);
      end
      RST_N = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check3("post_reset", K00, K00, K00);
      end

      // directed table
      for (int i = 0; i < NV + 2; i++) begin
         @(negedge CLK);
         if (i >= 2) check3($sformatf("vec%0d", i - 2), vecs[i-2].er, vecs[i-2].eg, vecs[i-2].eb);
         if (i < NV) drive(vecs[i].rdy, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
         else        drive(0,0,0, 8'h00,8'h00,8'h00);
      end

      // randomised run against the model, pipeline holds two idle symbols
      mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
      exp_q.push_back({K00, K00, K00});
      exp_q.push_back({K00, K00, K00});
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLK);
         e = exp_q.pop_front();
         check3("rand", e[29:20], e[19:10], e[9:0]);
         rdy = ((k % 80) < 64);
         hs  = 1'($urandom_range(0, 1));
         vs  = 1'($urandom_range(0, 1));
         r   = 8'($urandom_range(0, 255));
         g   = 8'($urandom_range(0, 255));
         b   = 8'($urandom_range(0, 255));
         drive(rdy, hs, vs, r, g, b);
         exp_q.push_back({model_enc(0, rdy, 2'b00, r), model_enc(1, rdy, 2'b00, g),
                          model_enc(2, rdy, {vs, hs}, b)});
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         e = exp_q.pop_front();
         check3("rand_drain", e[29:20], e[19:10], e[9:0]);
         drive(0,0,0, 8'h00,8'h00,8'h00);
      end

      // reset mid-line: outputs return to the reset token without a clock edge
      @(negedge CLK);
      drive(1,0,0, 8'h01,8'h01,8'h01);
      @(negedge CLK);
      drive(1,0,0, 8'h01,8'h01,8'h01);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check3("async_reset", K00, K00, K00);
      @(negedge CLK);
      check3("reset_hold", K00, K00, K00);
      RST_N = 1'b1;
      drive(1,0,0, 8'h00,8'h00,8'h00);
      @(negedge CLK);
      check3("release_c1", K00, K00, K00);
      drive(0,0,0, 8'h00,8'h00,8'h00);
      @(negedge CLK);
      check3("release_c2", Z0, Z0, Z0);
      @(negedge CLK);
      check3("release_c3", K00, K00, K00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
